hls_run_sequencer: RTL and testbench

Synthesizable run controller for Bambu-generated accelerators: drives reset/start of N_CH accelerator instances, measures per-channel latency in clock cycles, enforces a watchdog timeout, repeats the run a programmable number of times, and streams one result record per channel per run over a valid/ready port. Sits between the campaign host (or on-chip test harness) and the accelerator `start_port`/`done_port` pins, replacing file-based cycle counting with hardware measurement.

---
 rtl/hls_seq_pkg.sv | 38 +++
 rtl/hls_seq_capture.sv | 61 ++++++
 rtl/hls_run_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_hls_run_sequencer.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hls_seq_pkg.sv
// ---------------------------------------------------------------------------
// hls_seq_pkg
// Shared types for the HLS run sequencer: the controller state enum, the
// result status codes streamed on res_status, and the per-channel capture
// record handed from the capture slices to the reporting logic.
// ---------------------------------------------------------------------------
package hls_seq_pkg;

  // Controller states, in the order a run walks through them.
  typedef enum logic [2:0] {
    S_IDLE,
    S_RST0,
    S_RST1,
    S_START,
    S_RUN,
    S_REPORT,
    S_NEXT,
    S_FIN
  } seq_state_t;

  // Status codes carried on res_status.
  localparam logic [1:0] ST_FAIL    = 2'd0;
  localparam logic [1:0] ST_PASS    = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;

  // Flags half of a channel's result record; the latency lives next to it
  // because its width is a module parameter.
  typedef struct packed {
    logic       captured;
    logic [1:0] status;
  } cap_rec_t;

  // Status of a channel that raised done with the given self-check flag.
  function automatic logic [1:0] status_of(input logic pass);
    return pass ? ST_PASS : ST_FAIL;
  endfunction

endpackage

// File: rtl/hls_seq_capture.sv
// ---------------------------------------------------------------------------
// hls_seq_capture
// One channel's measurement slice. Latches the cycle count and pass flag on
// the first done of a run and ignores any later done until the next clear.
// When the controller fires the watchdog, an uncaptured channel records the
// current count (the timeout value) with timeout status; a done in that same
// cycle takes priority.
//
// Ports:
//   clock, reset    system clock, synchronous active-high reset
//   clear           high in the START cycle; restarts the slice and still
//                   captures a done arriving in that same cycle
//   enable          high during RUN
//   force_timeout   watchdog expiry, only meaningful with enable
//   done, pass      accelerator done_port and self-check result
//   count           latency value of the current cycle
//   rec             captured flag and status
//   cycles          latched latency
// ---------------------------------------------------------------------------
module hls_seq_capture
  import hls_seq_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic             force_timeout,
  input  logic             done,
  input  logic             pass,
  input  logic [CNT_W-1:0] count,
  output cap_rec_t         rec,
  output logic [CNT_W-1:0] cycles
);

  // First done wins; a clear doubles as the START-cycle capture so a done
  // coinciding with acc_start measures as one cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      rec.captured <= 1'b0;
      rec.status   <= ST_FAIL;
      cycles       <= '0;
    end else if (clear) begin
      rec.captured <= done;
      rec.status   <= done ? status_of(pass) : ST_FAIL;
      cycles       <= done ? count : '0;
    end else if (enable && !rec.captured) begin
      if (done) begin
        rec.captured <= 1'b1;
        rec.status   <= status_of(pass);
        cycles       <= count;
      end else if (force_timeout) begin
        rec.captured <= 1'b1;
        rec.status   <= ST_TIMEOUT;
        cycles       <= count;
      end
    end
  end

endmodule

// File: rtl/hls_run_sequencer.sv
// ---------------------------------------------------------------------------
// hls_run_sequencer
// Run controller for Bambu-generated accelerators. For each run of a
// campaign it resets all N_CH accelerators for two cycles, pulses start,
// measures each channel's latency with a watchdog, then streams one result
// record per channel over a valid/ready port. Campaigns repeat the run
// num_runs times (0 counts as 1).
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   go                  campaign start pulse, ignored while busy
//   num_runs            runs per campaign, latched when go is accepted
//   acc_reset           accelerator resets (active-high)
//   acc_start           one-cycle start pulse to every channel
//   acc_done, acc_pass  accelerator done_port and self-check result
//   res_valid/ready     result record handshake
//   res_ch, res_run     channel index and 0-based run index of the record
//   res_cycles          measured latency in cycles (start cycle counts as 1)
//   res_status          ST_FAIL / ST_PASS / ST_TIMEOUT
//   busy                campaign in progress
//   campaign_done       one-cycle pulse after the final record
//
// Optional feature, macro SEQ_STATS_EN: adds stat_min / stat_max (latency
// range over pass and fail records) and stat_fail (fail plus timeout
// record count), cleared by reset and by an accepted go.
// ---------------------------------------------------------------------------
module hls_run_sequencer
  import hls_seq_pkg::*;
#(
  parameter int N_CH    = 1,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 200000000,
  parameter int RUNS_W  = 8,
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int FAIL_W = RUNS_W + $clog2(N_CH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              go,
  input  logic [RUNS_W-1:0] num_runs,
  output logic [N_CH-1:0]   acc_reset,
  output logic [N_CH-1:0]   acc_start,
  input  logic [N_CH-1:0]   acc_done,
  input  logic [N_CH-1:0]   acc_pass,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CH_W-1:0]   res_ch,
  output logic [RUNS_W-1:0] res_run,
  output logic [CNT_W-1:0]  res_cycles,
  output logic [1:0]        res_status,
  output logic              busy,
  output logic              campaign_done
`ifdef SEQ_STATS_EN
  ,
  output logic [CNT_W-1:0]  stat_min,
  output logic [CNT_W-1:0]  stat_max,
  output logic [FAIL_W-1:0] stat_fail
`endif
);

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
  // Counter value during the first RUN cycle; saturates for tiny watchdogs.
  localparam logic [CNT_W-1:0] CNT_RUN0 = (TIMEOUT > 1) ? CNT_W'(2) : TMO;
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(N_CH - 1);

  seq_state_t        state;
  logic [CNT_W-1:0]  counter;
  logic [RUNS_W-1:0] run_idx;
  logic [RUNS_W-1:0] runs_lat;
  logic [CH_W-1:0]   rep_idx;

  logic [CNT_W-1:0]  cur_count;
  logic [CH_W-1:0]   next_idx;
  logic [CH_W-1:0]   load_idx;
  logic [RUNS_W-1:0] run_next;
  logic              cap_clear;
  logic              cap_enable;
  logic              cap_timeout;
  logic              all_seen;

  cap_rec_t          cap_rec    [N_CH];
  logic [CNT_W-1:0]  cap_cycles [N_CH];
  logic [N_CH-1:0]   cap_done;

  // Latency reported for a done seen this cycle: the START cycle counts as
  // 1, and the register holds the value for each RUN cycle.
  always_comb begin
    cur_count   = (state == S_START) ? CNT_W'(1) : counter;
    cap_clear   = (state == S_START);
    cap_enable  = (state == S_RUN);
    cap_timeout = (state == S_RUN) && (counter == TMO);
    next_idx    = rep_idx + 1'b1;
    load_idx    = res_valid ? next_idx : rep_idx;
    run_next    = run_idx + 1'b1;
    all_seen    = &(cap_done | acc_done);
  end

  genvar g;
  generate
    for (g = 0; g < N_CH; g++) begin : g_cap
      hls_seq_capture #(
        .CNT_W(CNT_W)
      ) u_cap (
        .clock        (clock),
        .reset        (reset),
        .clear        (cap_clear),
        .enable       (cap_enable),
        .force_timeout(cap_timeout),
        .done         (acc_done[g]),
        .pass         (acc_pass[g]),
        .count        (cur_count),
        .rec          (cap_rec[g]),
        .cycles       (cap_cycles[g])
      );
      assign cap_done[g] = cap_rec[g].captured;
    end
  endgenerate

  // Campaign FSM. All outputs are registered and set on the transition into
  // the state that owns them, so acc_reset covers RST0/RST1 exactly and
  // acc_start covers START exactly. In REPORT the first record is loaded the
  // cycle after entry; each accepted record loads the next one in the same
  // edge so transfers can run back to back.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_IDLE;
      counter       <= '0;
      run_idx       <= '0;
      runs_lat      <= '0;
      rep_idx       <= '0;
      acc_reset     <= '0;
      acc_start     <= '0;
      res_valid     <= 1'b0;
      res_ch        <= '0;
      res_run       <= '0;
      res_cycles    <= '0;
      res_status    <= ST_FAIL;
      busy          <= 1'b0;
      campaign_done <= 1'b0;
    end else begin
      acc_start     <= '0;
      campaign_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (go) begin
            state     <= S_RST0;
            runs_lat  <= (num_runs == '0) ? RUNS_W'(1) : num_runs;
            run_idx   <= '0;
            acc_reset <= '1;
            busy      <= 1'b1;
          end
        end
        S_RST0: begin
          state <= S_RST1;
        end
        S_RST1: begin
          acc_reset <= '0;
          acc_start <= '1;
          state     <= S_START;
        end
        S_START: begin
          counter <= CNT_RUN0;
          state   <= S_RUN;
        end
        S_RUN: begin
          if (counter != TMO) begin
            counter <= counter + 1'b1;
          end
          if (all_seen || (counter == TMO)) begin
            rep_idx <= '0;
            state   <= S_REPORT;
          end
        end
        S_REPORT: begin
          if (!res_valid || res_ready) begin
            if (res_valid && (rep_idx == LAST_CH)) begin
              res_valid <= 1'b0;
              state     <= S_NEXT;
            end else begin
              res_valid  <= 1'b1;
              rep_idx    <= load_idx;
              res_ch     <= load_idx;
              res_run    <= run_idx;
              res_cycles <= cap_cycles[load_idx];
              res_status <= cap_rec[load_idx].status;
            end
          end
        end
        S_NEXT: begin
          run_idx <= run_next;
          if (run_next == runs_lat) begin
            campaign_done <= 1'b1;
            state         <= S_FIN;
          end else begin
            acc_reset <= '1;
            state     <= S_RST0;
          end
        end
        S_FIN: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef SEQ_STATS_EN
  // Running statistics over accepted records. Timeouts carry no real
  // latency, so they only bump the failure count.
  always_ff @(posedge clock) begin
    if (reset || ((state == S_IDLE) && go)) begin
      stat_min  <= '1;
      stat_max  <= '0;
      stat_fail <= '0;
    end else if ((state == S_REPORT) && res_valid && res_ready) begin
      if (res_status != ST_TIMEOUT) begin
        if (res_cycles < stat_min) stat_min <= res_cycles;
        if (res_cycles > stat_max) stat_max <= res_cycles;
      end
      if (res_status != ST_PASS) begin
        stat_fail <= stat_fail + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hls_run_sequencer.sv
// ---------------------------------------------------------------------------
// tb_hls_run_sequencer
// Drives three modelled accelerators with programmable done offsets and
// checks every streamed record against expectations derived from the
// offsets: a channel finishing o cycles after its start cycle reports o+1
// with its pass flag, unless o+1 exceeds the watchdog, in which case it
// reports the watchdog value with timeout status.
// ---------------------------------------------------------------------------
module tb_hls_run_sequencer;

  localparam int N_CH    = 3;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 20;
  localparam int RUNS_W  = 4;
  localparam int CH_W    = 2;
  localparam int NEVER   = 1000;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              go = 1'b0;
  logic [RUNS_W-1:0] num_runs = '0;
  logic [N_CH-1:0]   acc_reset;
  logic [N_CH-1:0]   acc_start;
  logic [N_CH-1:0]   acc_done = '0;
  logic [N_CH-1:0]   acc_pass = '0;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [CH_W-1:0]   res_ch;
  logic [RUNS_W-1:0] res_run;
  logic [CNT_W-1:0]  res_cycles;
  logic [1:0]        res_status;
  logic              busy;
  logic              campaign_done;
`ifdef SEQ_STATS_EN
  logic [CNT_W-1:0]  stat_min;
  logic [CNT_W-1:0]  stat_max;
  logic [6:0]        stat_fail;
`endif

  hls_run_sequencer #(
    .N_CH   (N_CH),
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT),
    .RUNS_W (RUNS_W)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .go           (go),
    .num_runs     (num_runs),
    .acc_reset    (acc_reset),
    .acc_start    (acc_start),
    .acc_done     (acc_done),
    .acc_pass     (acc_pass),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_ch       (res_ch),
    .res_run      (res_run),
    .res_cycles   (res_cycles),
    .res_status   (res_status),
    .busy         (busy),
    .campaign_done(campaign_done)
`ifdef SEQ_STATS_EN
    ,
    .stat_min     (stat_min),
    .stat_max     (stat_max),
    .stat_fail    (stat_fail)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    int ch;
    int run;
    int cycles;
    int status;
  } rec_t;

  int   checks = 0;
  int   errors = 0;
  rec_t exp_q[$];
  rec_t got[$];

  // Accelerator model and bookkeeping.
  int   off [N_CH];
  bit   pas [N_CH];
  int   age [N_CH];
  bit   active = 0;
  bit   forced = 0;
  int   forced_off [N_CH];
  bit   forced_pas [N_CH];
  int   starts = 0;
  int   rst_pulses = 0;
  int   cdone_cnt = 0;
  int   go_age = -1;
  int   cycle_no = 0;
  int   ready_mode = 0;
  bit   prev_start = 0;
  bit   prev_rst = 0;
  bit   prev_stall = 0;
  bit   chk_reset = 0;
  logic [CH_W+RUNS_W+CNT_W+1:0] prev_payload;
`ifdef SEQ_STATS_EN
  logic [CNT_W-1:0] m_min;
  logic [CNT_W-1:0] m_max;
  int               m_fail;
`endif

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)",
               name, actual, expected, cycle_no);
    end
  endtask

  function automatic rec_t modelRec(input int ch, input int run, input int o,
                                    input bit p);
    rec_t r;
    r.ch  = ch;
    r.run = run;
    if (o + 1 <= TIMEOUT) begin
      r.cycles = o + 1;
      r.status = p ? 1 : 0;
    end else begin
      r.cycles = TIMEOUT;
      r.status = 2;
    end
    return r;
  endfunction

  // One clock cycle: sample and check outputs at the falling edge, then
  // drive the inputs for the next rising edge.
  task automatic applyStimulus(input bit go_in, input bit rst_in);
    rec_t e;
    rec_t d;
    @(negedge clock);
    cycle_no++;

    if (chk_reset) begin
      chk_reset = 0;
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_acc_reset", acc_reset, 0);
      checkOutput("rst_acc_start", acc_start, 0);
      checkOutput("rst_valid", res_valid, 0);
      checkOutput("rst_payload", {res_ch, res_run, res_cycles, res_status}, 0);
      checkOutput("rst_cdone", campaign_done, 0);
    end

    if (go_age >= 0) begin
      go_age++;
      case (go_age)
        1: begin
          checkOutput("go_rst_t1", acc_reset, {N_CH{1'b1}});
          checkOutput("go_busy", busy, 1);
        end
        2: checkOutput("go_rst_t2", acc_reset, {N_CH{1'b1}});
        default: begin
          checkOutput("go_start_t3", acc_start, {N_CH{1'b1}});
          checkOutput("go_rst_off_t3", acc_reset, 0);
          go_age = -1;
        end
      endcase
    end

    if (prev_start) checkOutput("start_one_cycle", acc_start, 0);

    if (prev_stall) begin
      checkOutput("stall_valid", res_valid, 1);
      checkOutput("stall_payload", {res_ch, res_run, res_cycles, res_status},
                  prev_payload);
    end

    if ((acc_reset != 0) && !prev_rst) begin
      rst_pulses++;
      for (int i = 0; i < N_CH; i++) begin
        if (forced) begin
          off[i] = forced_off[i];
          pas[i] = forced_pas[i];
        end else begin
          off[i] = ($urandom_range(0, 7) == 0) ? NEVER : $urandom_range(0, 22);
          pas[i] = 1'($urandom_range(0, 1));
        end
      end
    end
    prev_rst = (acc_reset != 0);

    if (acc_start != 0) begin
      starts++;
      for (int i = 0; i < N_CH; i++) begin
        exp_q.push_back(modelRec(i, starts - 1, off[i], pas[i]));
        age[i] = 0;
      end
      active = 1;
    end else if (active) begin
      for (int i = 0; i < N_CH; i++) age[i]++;
    end
    prev_start = (acc_start != 0);

    if (campaign_done === 1'b1) begin
      cdone_cnt++;
      checkOutput("records_before_done", exp_q.size(), 0);
    end

    // A repeat done two cycles later with the opposite pass flag must not
    // disturb the first capture.
    for (int i = 0; i < N_CH; i++) begin
      acc_done[i] = active && ((age[i] == off[i]) || (age[i] == off[i] + 2));
      acc_pass[i] = (age[i] == off[i]) ? pas[i] : !pas[i];
    end
    case (ready_mode)
      0:       res_ready = 1'b1;
      1:       res_ready = cycle_no[0];
      default: res_ready = 1'($urandom_range(0, 1));
    endcase

    if ((res_valid === 1'b1) && res_ready && !rst_in) begin
      if (exp_q.size() == 0) begin
        checkOutput("rec_unexpected", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        checkOutput("rec_ch", res_ch, e.ch);
        checkOutput("rec_run", res_run, e.run);
        checkOutput("rec_cycles", res_cycles, e.cycles);
        checkOutput("rec_status", res_status, e.status);
`ifdef SEQ_STATS_EN
        if (e.status != 2) begin
          if (CNT_W'(e.cycles) < m_min) m_min = CNT_W'(e.cycles);
          if (CNT_W'(e.cycles) > m_max) m_max = CNT_W'(e.cycles);
        end
        if (e.status != 1) m_fail++;
`endif
      end
      d.ch = int'(res_ch);
      d.run = int'(res_run);
      d.cycles = int'(res_cycles);
      d.status = int'(res_status);
      got.push_back(d);
    end
    prev_stall   = (res_valid === 1'b1) && !res_ready && !rst_in;
    prev_payload = {res_ch, res_run, res_cycles, res_status};

    go = go_in;
    if (go_in && (busy === 1'b0) && !rst_in) begin
      go_age     = 0;
      starts     = 0;
      rst_pulses = 0;
      got.delete();
`ifdef SEQ_STATS_EN
      m_min  = '1;
      m_max  = '0;
      m_fail = 0;
`endif
    end

    reset = rst_in;
    if (rst_in) begin
      exp_q.delete();
      active     = 0;
      go_age     = -1;
      prev_start = 0;
      prev_stall = 0;
      chk_reset  = 1;
    end
  endtask

  task automatic runCampaign(input int runs, input int mode, input bit inject_go);
    int exp_runs;
    int start_cd;
    bit seen;
    exp_runs   = (runs == 0) ? 1 : runs;
    start_cd   = cdone_cnt;
    seen       = 0;
    num_runs   = RUNS_W'(runs);
    ready_mode = mode;
    applyStimulus(1, 0);
    for (int k = 0; k < 3000 && !seen; k++) begin
      applyStimulus(inject_go && (k == 40), 0);
      if (cdone_cnt != start_cd) seen = 1;
    end
    checkOutput("campaign_done_seen", seen, 1);
    checkOutput("runs_started", starts, exp_runs);
    checkOutput("records_left", exp_q.size(), 0);
    applyStimulus(0, 0);
    checkOutput("cdone_one_cycle", campaign_done, 0);
    checkOutput("idle_busy", busy, 0);
`ifdef SEQ_STATS_EN
    checkOutput("stat_min", stat_min, m_min);
    checkOutput("stat_max", stat_max, m_max);
    checkOutput("stat_fail", stat_fail, m_fail);
`endif
  endtask

  task automatic checkRec(input int k, input int ch, input int run,
                          input int cyc, input int st);
    if (got.size() > k) begin
      checkOutput("lit_ch", got[k].ch, ch);
      checkOutput("lit_run", got[k].run, run);
      checkOutput("lit_cycles", got[k].cycles, cyc);
      checkOutput("lit_status", got[k].status, st);
    end else begin
      checkOutput("lit_missing", got.size(), k + 1);
    end
  endtask

  task automatic forceRun(input int o0, input int o1, input int o2,
                          input bit p0, input bit p1, input bit p2);
    forced        = 1;
    forced_off[0] = o0;
    forced_off[1] = o1;
    forced_off[2] = o2;
    forced_pas[0] = p0;
    forced_pas[1] = p1;
    forced_pas[2] = p2;
  endtask

  initial begin
    int cd_before;
    applyStimulus(0, 1);
    applyStimulus(0, 1);
    applyStimulus(0, 0);

    // Staggered completions with mixed pass flags.
    forceRun(0, 4, 2, 1, 0, 1);
    runCampaign(1, 0, 0);
    checkOutput("lit_count_a", got.size(), 3);
    checkRec(0, 0, 0, 1, 1);
    checkRec(1, 1, 0, 5, 0);
    checkRec(2, 2, 0, 3, 1);

    // Done nine cycles after start measures ten.
    forceRun(9, 0, 1, 1, 1, 1);
    runCampaign(1, 2, 0);
    checkRec(0, 0, 0, 10, 1);

    // Watchdog: a silent channel times out and the next run still starts.
    forceRun(3, NEVER, 5, 1, 1, 0);
    runCampaign(2, 0, 0);
    checkRec(1, 1, 0, TIMEOUT, 2);
    checkRec(4, 1, 1, TIMEOUT, 2);
    checkOutput("timeout_rst_pulses", rst_pulses, 2);

    // Done on the watchdog cycle still wins.
    forceRun(19, 2, 25, 1, 0, 1);
    runCampaign(1, 0, 0);
    checkRec(0, 0, 0, TIMEOUT, 1);
    checkRec(2, 2, 0, TIMEOUT, 2);

    // Three runs with a toggling consumer, then num_runs=0.
    forced = 0;
    runCampaign(3, 1, 0);
    checkOutput("lit_count_3runs", got.size(), 9);
    checkRec(3, 0, 1, got.size() > 3 ? got[3].cycles : 0,
             got.size() > 3 ? got[3].status : 0);
    checkOutput("lit_run2", got.size() > 6 ? got[6].run : -1, 2);
    runCampaign(0, 0, 0);
    checkOutput("lit_count_zero_runs", got.size(), 3);

    // go while busy is ignored.
    forceRun(12, 14, 16, 1, 1, 0);
    runCampaign(2, 2, 1);
    checkOutput("busy_go_records", got.size(), 6);

    // Reset during the RUN of run 1.
    forceRun(10, 10, 10, 1, 1, 1);
    num_runs   = 4'd3;
    ready_mode = 0;
    applyStimulus(1, 0);
    for (int k = 0; k < 2000 && starts < 2; k++) applyStimulus(0, 0);
    checkOutput("reached_run1", starts, 2);
    applyStimulus(0, 0);
    applyStimulus(0, 0);
    cd_before = cdone_cnt;
    applyStimulus(0, 1);
    for (int k = 0; k < 30; k++) applyStimulus(0, 0);
    checkOutput("no_cdone_after_reset", cdone_cnt, cd_before);
    checkOutput("reset_busy_low", busy, 0);
    forced = 0;
    runCampaign(2, 0, 0);
    checkRec(0, 0, 0, got.size() > 0 ? got[0].cycles : 0,
             got.size() > 0 ? got[0].status : 0);

    // Random campaigns.
    for (int c = 0; c < 8; c++) begin
      runCampaign($urandom_range(0, 4), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
